// File: rtl/ps2_pkg.sv
// Shared PS/2 frame constants, receiver FSM state encoding and parity helper.
package ps2_pkg;

    localparam int          PS2_DATA_BITS  = 8;
    localparam logic        PS2_START_BIT  = 1'b0;
    localparam logic        PS2_STOP_BIT   = 1'b1;
    localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] dat, input logic par);
        return ^{dat, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchroniser, FILTER_LEN-cycle debounce and registered falling-edge pulse.
// fall rises FILTER_LEN+3 cycles after the pin falls; no backpressure (free-running).
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_25mhz,
    input  logic resetn,
    input  logic line_in,
    output logic fall
);

    localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);

    logic       meta_q;
    logic       sync_q;
    logic       filt_q;
    logic       filt_prev_q;
    logic [7:0] cnt_q;

    // Idle bus is high, so every stage resets to 1 to avoid a spurious edge.
    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            meta_q      <= 1'b1;
            sync_q      <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            cnt_q       <= 8'd0;
            fall        <= 1'b0;
        end else begin
            meta_q      <= line_in;
            sync_q      <= meta_q;
            filt_prev_q <= filt_q;
            fall        <= filt_prev_q & ~filt_q;
            if (sync_q == filt_q) begin
                cnt_q <= 8'd0;
            end else if (cnt_q == CNT_LAST) begin
                filt_q <= sync_q;
                cnt_q  <= 8'd0;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: rtl/ps2_recv.sv
// Host-side PS/2 byte receiver; optional F0 break-prefix decoding under PS2_BREAK_DECODE_EN.
// Strobes land FILTER_LEN+4 cycles after the stop-bit clock fall; no backpressure, strobes are 1 cycle.
module ps2_recv
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 8192
) (
    input  logic       clk_25mhz,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_break,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int              TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

    logic            fall;
    logic            data_meta_q;
    logic            data_sync_q;

    ps2_state_e      state_q,  state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q,  shift_d;
    logic            parity_q, parity_d;
    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_hit;

    logic [7:0]      rx_data_d;
    logic            rx_valid_d;
    logic            parity_err_d;
    logic            frame_err_d;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk_25mhz (clk_25mhz),
        .resetn    (resetn),
        .line_in   (ps2_clk),
        .fall      (fall)
    );

    // Data is only sampled on a filtered clock fall, long after it settles.
    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
        end
    end

    assign timeout_hit = (to_cnt_q == TO_MAX);

    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            to_cnt_q <= '0;
        end else if (state_q == IDLE || fall) begin
            to_cnt_q <= '0;
        end else if (!timeout_hit) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

`ifdef PS2_BREAK_DECODE_EN
    logic break_pending_q, break_pending_d;
    logic rx_break_q, rx_break_d;
    assign rx_break = rx_break_q;
`else
    assign rx_break = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        rx_data_d    = rx_data;
        rx_valid_d   = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef PS2_BREAK_DECODE_EN
        break_pending_d = break_pending_q;
        rx_break_d      = rx_break_q;
`endif

        case (state_q)
            IDLE: begin
                if (fall && data_sync_q == PS2_START_BIT) begin
                    state_d   = DATA;
                    bit_cnt_d = 4'd0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(PS2_DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_d = data_sync_q;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (data_sync_q != PS2_STOP_BIT) begin
                        frame_err_d = 1'b1;
                    end else if (!odd_parity_ok(shift_q, parity_q)) begin
                        parity_err_d = 1'b1;
                    end else begin
`ifdef PS2_BREAK_DECODE_EN
                        if (shift_q == PS2_BREAK_CODE) begin
                            break_pending_d = 1'b1;
                        end else begin
                            rx_valid_d      = 1'b1;
                            rx_data_d       = shift_q;
                            rx_break_d      = break_pending_q;
                            break_pending_d = 1'b0;
                        end
`else
                        rx_valid_d = 1'b1;
                        rx_data_d  = shift_q;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A coincident fall has already advanced the frame, so it beats the timeout.
        if (state_q != IDLE && !fall && timeout_hit) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
        end

`ifdef PS2_BREAK_DECODE_EN
        if (parity_err_d || frame_err_d) begin
            break_pending_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            parity_q   <= 1'b0;
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            rx_data    <= rx_data_d;
            rx_valid   <= rx_valid_d;
            parity_err <= parity_err_d;
            frame_err  <= frame_err_d;
        end
    end

`ifdef PS2_BREAK_DECODE_EN
    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            break_pending_q <= 1'b0;
            rx_break_q      <= 1'b0;
        end else begin
            break_pending_q <= break_pending_d;
            rx_break_q      <= rx_break_d;
        end
    end
`endif

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_recv.sv
// Directed-vector bench for ps2_recv; expectations hand-derived from the PS/2 frame format.
module tb_ps2_recv;

    localparam int FLEN = 8;
    localparam int TOUT = 8192;
    localparam int FAST = 64;

    logic       clk_25mhz = 1'b0;
    logic       resetn    = 1'b0;
    logic       ps2_clk   = 1'b1;
    logic       ps2_data  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_break;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int fall_cyc    = 0;
    int v_cnt = 0, pe_cnt = 0, fe_cnt = 0;
    int last_v_cyc = 0;
    logic [8:0] hist[$];

    ps2_recv #(
        .FILTER_LEN (FLEN),
        .TIMEOUT    (TOUT)
    ) dut (
        .clk_25mhz  (clk_25mhz),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_break   (rx_break),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    always @(posedge clk_25mhz) cyc <= cyc + 1;

    // Strobe log: counts high cycles, so a strobe stuck for 2 cycles counts twice.
    always @(negedge clk_25mhz) begin
        if (rx_valid) begin
            v_cnt++;
            last_v_cyc = cyc;
            hist.push_back({rx_break, rx_data});
        end
        if (parity_err) pe_cnt++;
        if (frame_err)  fe_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_25mhz);
    endtask

    task automatic send_bit(input logic b, input int half);
        ps2_data = b;
        wait_cyc(half);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        wait_cyc(half);
        ps2_clk  = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int half);
        send_bit(1'b0, half);
        for (int i = 0; i < 8; i++) send_bit(d[i], half);
        send_bit(par, half);
        send_bit(stp, half);
        ps2_data = 1'b1;
        wait_cyc(half);
    endtask

    task automatic send_good(input logic [7:0] d, input int half);
        send_frame(d, ~^d, 1'b1, half);
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        wait_cyc(5);
        vectors++;
        if ({rx_data, rx_valid, rx_break, parity_err, frame_err, busy} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {rx_data, rx_valid, rx_break, parity_err, frame_err, busy});
        end
        resetn = 1'b1;
        wait_cyc(30);
        vectors++;
        if (busy !== 1'b0 || v_cnt + pe_cnt + fe_cnt != 0) begin
            miscompares++;
            $display("FAIL reset_idle: busy %b strobes %0d expected busy 0 strobes 0",
                     busy, v_cnt + pe_cnt + fe_cnt);
        end
    endtask

    task automatic test_single;
        int v0 = v_cnt, p0 = pe_cnt, f0 = fe_cnt;
        send_good(8'h1C, 1024);
        check_val("single_count", 32'(v_cnt - v0), 32'd1);
        check_val("single_data", 32'(rx_data), 32'h1C);
        check_val("single_break", 32'(hist[hist.size()-1][8]), 32'd0);
        check_val("single_errs", 32'((pe_cnt - p0) + (fe_cnt - f0)), 32'd0);
        check_val("single_busy", 32'(busy), 32'd0);
        check_val("single_latency", 32'(last_v_cyc - fall_cyc), 32'(FLEN + 4));
    endtask

    task automatic test_break_seq;
        int v0 = v_cnt;
        int h0 = hist.size();
        send_good(8'h1C, FAST);
        send_good(8'hF0, FAST);
        send_good(8'h1C, FAST);
`ifdef PS2_BREAK_DECODE_EN
        check_val("brk_count", 32'(v_cnt - v0), 32'd2);
        if (hist.size() >= h0 + 2) begin
            check_val("brk_first", 32'(hist[h0]), 32'h01C);
            check_val("brk_second", 32'(hist[h0+1]), 32'h11C);
        end
        v0 = v_cnt;
        h0 = hist.size();
        send_good(8'hF0, FAST);
        send_good(8'hF0, FAST);
        send_good(8'h1C, FAST);
        check_val("brk_f0f0_count", 32'(v_cnt - v0), 32'd1);
        if (hist.size() >= h0 + 1) check_val("brk_f0f0_byte", 32'(hist[h0]), 32'h11C);
`else
        check_val("brk_count", 32'(v_cnt - v0), 32'd3);
        if (hist.size() >= h0 + 3) begin
            check_val("brk_first", 32'(hist[h0]), 32'h01C);
            check_val("brk_second", 32'(hist[h0+1]), 32'h0F0);
            check_val("brk_third", 32'(hist[h0+2]), 32'h01C);
        end
`endif
    endtask

    task automatic test_parity_err;
        int v0 = v_cnt, p0 = pe_cnt, f0 = fe_cnt;
        send_frame(8'h00, 1'b0, 1'b1, FAST);
        check_val("par_err_count", 32'(pe_cnt - p0), 32'd1);
        check_val("par_valid_count", 32'(v_cnt - v0), 32'd0);
        check_val("par_frame_count", 32'(fe_cnt - f0), 32'd0);
        check_val("par_data_held", 32'(rx_data), 32'h1C);
    endtask

    task automatic test_frame_err;
        int v0 = v_cnt, p0 = pe_cnt, f0 = fe_cnt;
        send_frame(8'h55, ~^8'h55, 1'b0, FAST);
        check_val("frm_err_count", 32'(fe_cnt - f0), 32'd1);
        check_val("frm_other_count", 32'((v_cnt - v0) + (pe_cnt - p0)), 32'd0);
        send_good(8'hAA, FAST);
        check_val("frm_next_count", 32'(v_cnt - v0), 32'd1);
        check_val("frm_next_data", 32'(rx_data), 32'hAA);
    endtask

    task automatic test_timeout;
        int v0 = v_cnt, f0 = fe_cnt;
        send_bit(1'b0, FAST);
        for (int i = 0; i < 4; i++) send_bit(1'b1, FAST);
        ps2_data = 1'b1;
        wait_cyc(FAST);
        check_val("to_busy_mid", 32'(busy), 32'd1);
        wait_cyc(TOUT + 100);
        check_val("to_frame_err", 32'(fe_cnt - f0), 32'd1);
        check_val("to_busy_after", 32'(busy), 32'd0);
        check_val("to_no_valid", 32'(v_cnt - v0), 32'd0);
        send_good(8'h1C, FAST);
        check_val("to_next_data", 32'(rx_data), 32'h1C);
        check_val("to_next_count", 32'(v_cnt - v0), 32'd1);
    endtask

    task automatic test_glitch;
        int s0 = v_cnt + pe_cnt + fe_cnt;
        ps2_data = 1'b0;
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(30);
        check_val("glitch_busy", 32'(busy), 32'd0);
        ps2_data = 1'b1;
        wait_cyc(10);
        check_val("glitch_strobes", 32'(v_cnt + pe_cnt + fe_cnt - s0), 32'd0);
    endtask

    task automatic test_reset_mid;
        int s0 = v_cnt + pe_cnt + fe_cnt;
        int v0 = v_cnt;
        send_bit(1'b0, FAST);
        for (int i = 0; i < 3; i++) send_bit(1'b1, FAST);
        check_val("rst_busy_before", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        check_val("rst_outputs", 32'({rx_data, rx_valid, rx_break, parity_err, frame_err, busy}), 32'd0);
        wait_cyc(5);
        resetn = 1'b1;
        wait_cyc(3 * FAST);
        check_val("rst_no_strobe", 32'(v_cnt + pe_cnt + fe_cnt - s0), 32'd0);
        send_good(8'h5A, FAST);
        check_val("rst_next_count", 32'(v_cnt - v0), 32'd1);
        check_val("rst_next_data", 32'(rx_data), 32'h5A);
    endtask

    initial begin
        test_reset();
        test_single();
        test_break_seq();
        test_parity_err();
        test_frame_err();
        test_timeout();
        test_glitch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_recv.md
Name: ps2_recv

Overview:
- Host-side PS/2 receiver, downstream of the PS/2 device-side sender (make / F0 / make keystroke emulator).
- Deserialises ps2_clk/ps2_data frames into bytes with parity/framing checks, glitch filtering and inactivity timeout.
- Output is a one-cycle byte strobe for a keyboard decoder or LED display.
- Sized for 25 MHz system clock and ~12 kHz PS/2 clock (1024-cycle half period).

Parameters:
- FILTER_LEN, 8, consecutive stable cycles required before filtered ps2_clk changes (range 2..255).
- TIMEOUT, 8192, cycles without filtered falling edge mid-frame before abort (range 16..65535).

Ports:
- clk_25mhz  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- ps2_clk  input  1  PS/2 clock line, asynchronous
- ps2_data  input  1  PS/2 data line, asynchronous
- rx_data  output  8  last received byte, held until next rx_valid
- rx_valid  output  1  one-cycle strobe, rx_data/rx_break valid
- rx_break  output  1  byte was preceded by F0 (feature-dependent)
- parity_err  output  1  one-cycle strobe, bad odd parity
- frame_err  output  1  one-cycle strobe, bad start/stop or timeout
- busy  output  1  frame in progress

Behaviour:
- Reset (async, resetn=0):
  - All outputs 0, state IDLE, bit count 0, shift register 0, break_pending 0.
  - Synchroniser and filter flops reset to 1 (idle bus).
  - Reset mid-frame discards the partial frame; no strobe is issued.
- Input conditioning:
  - Both lines pass through a 2-FF synchroniser.
  - ps2_clk additionally goes through a debounce filter. A counter clears whenever the synced value equals the filtered value. The filtered value takes the synced value once they have differed for FILTER_LEN consecutive cycles.
  - fall = registered pulse on filtered 1→0.
  - Data is sampled from synced ps2_data on the fall pulse.
- Frame format: start(0), D0..D7 LSB first, odd parity, stop(1). Eleven falls per frame.
- FSM (busy = state != IDLE):
  - IDLE: on fall with data=0 → DATA, bit count 0. A fall with data=1 is ignored (no error).
  - DATA: on each fall, shift the sampled bit in at bit 7 (right-shift); after the 8th → PARITY.
  - PARITY: on fall, latch parity bit → STOP.
  - STOP: on fall, evaluate in priority order, then → IDLE in all cases:
    - stop=0 → frame_err
    - else parity fails (XOR of 8 data bits and parity bit ≠ 1) → parity_err
    - else → rx_valid, rx_data updated
- Timing:
  - Latency from ps2_clk pin falling (stop bit) to strobe: FILTER_LEN+4 cycles exactly.
  - Strobes are registered and last exactly 1 cycle.
  - At most one of rx_valid/parity_err/frame_err is asserted per frame.
- Timeout:
  - Counter clears on every fall and in IDLE; it increments otherwise.
  - Reaching TIMEOUT in DATA/PARITY/STOP → frame_err pulse, → IDLE, break_pending cleared.
  - Timeout and fall in the same cycle: the fall wins and the counter clears.
- Width: timeout counter is $clog2(TIMEOUT+1) bits and saturates. Bit count is 4 bits.

Optional Feature:
- Macro: PS2_BREAK_DECODE_EN.
- Defined:
  - A valid byte 0xF0 produces no rx_valid and sets break_pending.
  - The next valid byte strobes with rx_break=1 and clears break_pending.
  - parity_err, frame_err or timeout also clear break_pending.
  - F0 F0 sequence: the second F0 is treated as break prefix again (still no strobe).
- Undefined: every valid byte, including 0xF0, strobes rx_valid; rx_break tied 0; no break_pending flop.

Decomposition:
- Package ps2_pkg:
  - Constants: PS2_DATA_BITS=8, PS2_START_BIT=0, PS2_STOP_BIT=1, PS2_BREAK_CODE=8'hF0.
  - FSM state enum {IDLE, DATA, PARITY, STOP}.
- Sub-module ps2_line_filter: synchroniser + debounce + registered falling-edge pulse, parameter FILTER_LEN. Instantiated once for ps2_clk; ps2_data uses the synchroniser only.

Test Plan:
- Frame 0x1C, parity 0, 1024-cycle half period → single rx_valid, rx_data=0x1C, no errors, busy low afterwards, latency FILTER_LEN+4 from final fall.
- Sequence 0x1C,0xF0,0x1C:
  - Macro off → three strobes 1C,F0,1C, rx_break=0.
  - Macro on → two strobes: 1C(break=0), 1C(break=1).
- Frame 0x00 with parity bit 0 → parity_err one pulse, no rx_valid, rx_data retains prior value.
- Frame 0x55, stop bit driven 0 → frame_err one pulse; following good frame 0xAA received normally.
- Clocking stops after 4 data bits, wait TIMEOUT+10 cycles → one frame_err pulse, busy=0; next 0x1C received OK.
- Disturbances:
  - 3-cycle low glitch on ps2_clk in IDLE with data=0 (FILTER_LEN=8) → no state change.
  - resetn pulsed low mid-frame → outputs 0 immediately, no strobe.
  - Next full frame → received OK.
